// File: rtl/btn_timer_arb.sv
// btn_timer_arb: round-robin arbiter that lends one shared timer to 4 requesters.
// Optional watchdog under BTN_TIMER_ARB_WDOG_EN (limit WD_MAX).
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   async active-high reset
//   req[3:0]   in   per-requester level request
//   timer_done in   shared timer expiry
//   timer_clr  out  shared timer clear (timer counts while 0)
//   gnt[3:0]   out  one-hot grant
//   done[3:0]  out  one-cycle expiry pulse to the owner
//   busy       out  FSM not idle
//   err        out  one-cycle watchdog timeout pulse (0 without watchdog)
module btn_timer_arb #(
  parameter int unsigned WD_MAX = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       timer_done,
  output logic       timer_clr,
  output logic [3:0] gnt,
  output logic [3:0] done,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [1:0] win;
  logic [3:0] own_oh;

  if (WD_MAX == 0 || WD_MAX > 255) begin : g_wd_range
    $error("WD_MAX must be in 1..255");
  end

`ifdef BTN_TIMER_ARB_WDOG_EN
  localparam logic [7:0] WdLim = 8'(WD_MAX);
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
`endif

  // Scan last+1 .. last+4; the first set bit wins.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
`ifdef BTN_TIMER_ARB_WDOG_EN
    wd_d    = wd_q;
    err_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = win;
          state_d = CLR;
        end
      end
      CLR: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else begin
          state_d = RUN;
`ifdef BTN_TIMER_ARB_WDOG_EN
          wd_d    = 8'd0;
`endif
        end
      end
      RUN: begin
        // Abandon takes priority over a coincident expiry.
        if (!req[owner_q]) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (timer_done) begin
          state_d = DONE;
        end else begin
`ifdef BTN_TIMER_ARB_WDOG_EN
          wd_d = wd_q + 8'd1;
          if (wd_d == WdLim) begin
            err_d   = 1'b1;
            state_d = IDLE;
            last_d  = owner_q;
          end
`endif
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef BTN_TIMER_ARB_WDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Outputs decode from registered state only, so reset forces them at once.
  assign own_oh    = 4'b0001 << owner_q;
  assign busy      = (state_q != IDLE);
  assign timer_clr = (state_q != RUN);
  assign gnt       = busy ? own_oh : 4'b0000;
  assign done      = (state_q == DONE) ? own_oh : 4'b0000;

endmodule

// File: tb/tb_btn_timer_arb.sv
// tb_btn_timer_arb: random + directed scoreboard bench for btn_timer_arb.
// Driver pushes expected grants; negedge monitor pops and compares.
module tb_btn_timer_arb;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       timer_done;
  logic       timer_clr;
  logic [3:0] gnt;
  logic [3:0] done;
  logic       busy;
  logic       err;

  btn_timer_arb #(.WD_MAX(255)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .timer_done (timer_done),
    .timer_clr  (timer_clr),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .err        (err)
  );

  typedef struct {
    logic [1:0] own;
    int         issue;
    bit         dn;
    int         runs;
  } exp_t;

  exp_t       sbq[$];
  int         n_chk;
  int         n_fail;
  int         cyc;
  logic [1:0] ptr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arbitration: first set bit after the pointer, mod 4.
  function automatic logic [1:0] rr_pick(input logic [1:0] p,
                                         input logic [3:0] m);
    for (int i = 1; i <= 4; i++) begin
      int idx;
      idx = (int'(p) + i) % 4;
      if (m[idx]) return 2'(idx);
    end
    return p;
  endfunction

  // Monitor
  initial begin
    bit         in_grant;
    exp_t       cur;
    logic [3:0] cur_gnt;
    int         run_cnt;
    int         done_cnt;
    in_grant = 0;
    cur_gnt  = 4'b0;
    run_cnt  = 0;
    done_cnt = 0;
    forever begin
      @(negedge clk);
      chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
      chk("done_in_gnt", 32'(done & ~gnt), 0);
      chk("err_zero", 32'(err), 0);
      if (in_grant) begin
        if (gnt == 4'b0) begin
          chk("run_cycles", run_cnt, cur.runs);
          chk("done_pulses", done_cnt, cur.dn ? 1 : 0);
          in_grant = 0;
        end else begin
          chk("gnt_stable", 32'(gnt), 32'(cur_gnt));
          if (!timer_clr) run_cnt++;
          if (done != 4'b0) begin
            done_cnt++;
            chk("done_owner", 32'(done), 32'(cur_gnt));
          end
        end
      end else if (gnt != 4'b0) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_grant: got %b want none", gnt);
        end else begin
          cur     = sbq.pop_front();
          cur_gnt = 4'b0001 << cur.own;
          chk("grant", 32'(gnt), 32'(cur_gnt));
          chk("grant_latency", cyc, cur.issue + 1);
          chk("clr_first_cycle", 32'(timer_clr), 1);
          run_cnt  = 0;
          done_cnt = 0;
          in_grant = 1;
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    @(negedge clk);
    req        = 4'b0;
    timer_done = 1'b0;
    k = 0;
    while (busy && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", 32'(busy), 0);
  endtask

  // mode 0: expiry, 1: abandon in RUN, 2: abandon + expiry, 3: abandon in CLR
  task automatic do_txn(input logic [3:0] mask, input int n, input int mode);
    logic [1:0] own;
    logic [3:0] oh;
    exp_t       e;
    @(negedge clk);
    own     = rr_pick(ptr, mask);
    oh      = 4'b0001 << own;
    e.own   = own;
    e.issue = cyc;
    e.dn    = (mode == 0);
    e.runs  = (mode == 3) ? 0 : n + 1;
    sbq.push_back(e);
    req        = mask;
    timer_done = 1'($urandom);
    @(negedge clk);
    timer_done = 1'($urandom);
    if (mode == 3) begin
      req = 4'($urandom) & ~oh;
    end else begin
      req = 4'($urandom) | oh;
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        timer_done = 1'b0;
        req        = 4'($urandom) | oh;
      end
      @(negedge clk);
      timer_done = (mode != 1);
      req        = (mode == 0) ? (req | oh) : (req & ~oh);
    end
    ptr = own;
    wait_idle();
  endtask

  // All four requesting with expiry held high: back-to-back 4-cycle grants.
  task automatic rr_burst();
    exp_t e;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      e.own   = rr_pick(ptr, 4'hF);
      e.issue = cyc + 4 * g;
      e.dn    = 1;
      e.runs  = 1;
      sbq.push_back(e);
      ptr = e.own;
    end
    req        = 4'hF;
    timer_done = 1'b1;
    repeat (19) @(posedge clk);
    @(negedge clk);
    req        = 4'b0;
    timer_done = 1'b0;
    wait_idle();
  endtask

  // Reset pulsed asynchronously after k RUN cycles of requester 3.
  task automatic reset_mid_run(input int k);
    exp_t e;
    @(negedge clk);
    e.own   = 2'd3;
    e.issue = cyc;
    e.dn    = 0;
    e.runs  = k;
    sbq.push_back(e);
    req        = 4'b1000;
    timer_done = 1'b0;
    @(negedge clk);
    repeat (k) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_timer_clr", 32'(timer_clr), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(negedge clk);
    req = 4'b0;
    @(negedge clk);
    reset = 1'b0;
    ptr   = 2'd3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    ptr        = 2'd3;
    reset      = 1'b0;
    req        = 4'b0;
    timer_done = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("init_gnt", 32'(gnt), 0);
    chk("init_done", 32'(done), 0);
    chk("init_busy", 32'(busy), 0);
    chk("init_clr", 32'(timer_clr), 1);
    chk("init_err", 32'(err), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    rr_burst();
    do_txn(4'b0001, 4, 0);
    do_txn(4'b0100, 2, 1);
    do_txn(4'b0110, 3, 0);
    do_txn(4'b1000, 2, 0);
    reset_mid_run(2);
    do_txn(4'b1110, 1, 0);
    do_txn(4'b0011, 0, 2);
    do_txn(4'b0101, 0, 3);

    for (int t = 0; t < 150; t++) begin
      do_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 6)),
             int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
